// File: rtl/cea_pkg.sv
// Shared types and constants for the completion egress arbiter: FSM states,
// destination subunit codes and completion header field positions.
package cea_pkg;

  localparam int unsigned CEA_HDR_WIDTH  = 96;
  localparam int unsigned CEA_PLD_WIDTH  = 32;
  localparam int unsigned CEA_DEST_WIDTH = 3;

  localparam logic [CEA_DEST_WIDTH-1:0] DEST_CFG = 3'd1;
  localparam logic [CEA_DEST_WIDTH-1:0] DEST_MEM = 3'd2;
  localparam logic [CEA_DEST_WIDTH-1:0] DEST_IO  = 3'd3;

  // Header fmt bit that marks a completion carrying a payload word
  localparam int unsigned FMT_DATA_BIT = 30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PLD  = 2'd2
  } cea_state_e;

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin pick: first requester searching upward from
// last_grant+1, wrapping; the pointer register lives in the parent.
module rr_arbiter_core #(
  parameter int unsigned NUM_LINKS = 4,
  localparam int unsigned IDX_W = $clog2(NUM_LINKS)
) (
  input  logic [NUM_LINKS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  input  logic                 enable,
  output logic [NUM_LINKS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    logic             found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    if (enable) begin
      for (int unsigned k = 1; k <= NUM_LINKS; k++) begin
        cand = IDX_W'((32'(last_grant) + k) % NUM_LINKS);
        if (!found && req[cand]) begin
          found           = 1'b1;
          grant[cand]     = 1'b1;
          grant_idx       = cand;
        end
      end
    end
  end

endmodule

// File: rtl/completion_egress_arbiter.sv
// Round-robin arbiter from per-link header sorters onto the subunit bus.
// Optional per-link grant counters: define CEA_GRANT_STATS_EN.
module completion_egress_arbiter
  import cea_pkg::*;
#(
  parameter int unsigned NUM_LINKS    = 4,
  parameter int unsigned HDR_WIDTH    = CEA_HDR_WIDTH,
  parameter int unsigned PLD_WIDTH    = CEA_PLD_WIDTH,
  parameter int unsigned DEST_WIDTH   = CEA_DEST_WIDTH,
  parameter int unsigned NUM_SUBUNITS = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_LINKS-1:0]            req_valid,
  input  logic [NUM_LINKS*HDR_WIDTH-1:0]  req_header,
  input  logic [NUM_LINKS*PLD_WIDTH-1:0]  req_payload,
  input  logic [NUM_LINKS*DEST_WIDTH-1:0] req_dest,
  output logic [NUM_LINKS-1:0]            req_ready,
  output logic                            out_valid,
  output logic [HDR_WIDTH-1:0]            out_header,
  output logic [PLD_WIDTH-1:0]            out_payload,
  output logic [DEST_WIDTH-1:0]           out_dest,
  output logic                            out_is_payload,
  output logic                            out_last,
  output logic [$clog2(NUM_LINKS)-1:0]    out_link_id,
  input  logic [NUM_SUBUNITS-1:0]         sub_ready,
  output logic                            err_drop
`ifdef CEA_GRANT_STATS_EN
  ,
  output logic [NUM_LINKS*16-1:0]         grant_count
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_LINKS);
  localparam int unsigned SUB_W = $clog2(NUM_SUBUNITS);

  logic [HDR_WIDTH-1:0]  hdr_arr  [NUM_LINKS];
  logic [PLD_WIDTH-1:0]  pld_arr  [NUM_LINKS];
  logic [DEST_WIDTH-1:0] dest_arr [NUM_LINKS];

  for (genvar i = 0; i < NUM_LINKS; i++) begin : g_unpack
    assign hdr_arr[i]  = req_header[i*HDR_WIDTH +: HDR_WIDTH];
    assign pld_arr[i]  = req_payload[i*PLD_WIDTH +: PLD_WIDTH];
    assign dest_arr[i] = req_dest[i*DEST_WIDTH +: DEST_WIDTH];
  end

  cea_state_e            state_q, state_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [HDR_WIDTH-1:0]  hdr_q, hdr_d;
  logic [PLD_WIDTH-1:0]  pld_q, pld_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic [IDX_W-1:0]      link_q, link_d;
  logic                  err_drop_d;
  logic                  out_valid_d, out_is_payload_d, out_last_d;
  logic [PLD_WIDTH-1:0]  out_payload_d;

  logic [NUM_LINKS-1:0]  grant;
  logic [IDX_W-1:0]      grant_idx;
  logic [DEST_WIDTH-1:0] sel_dest;
  logic                  dest_ok;
  logic                  accept;
  logic                  has_data;

  rr_arbiter_core #(
    .NUM_LINKS (NUM_LINKS)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .enable     ((state_q == IDLE) && rst_n),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign req_ready = grant;
  assign sel_dest  = dest_arr[grant_idx];
  assign dest_ok   = (sel_dest != '0) && (sel_dest <= DEST_WIDTH'(NUM_SUBUNITS - 1));
  assign accept    = out_valid && sub_ready[SUB_W'(dest_q)];
  assign has_data  = hdr_q[FMT_DATA_BIT];

  assign out_header  = hdr_q;
  assign out_dest    = dest_q;
  assign out_link_id = link_q;

  // Next-state and beat sequencing; out_* update only on transitions so they
  // stay put under backpressure and in IDLE.
  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    hdr_d            = hdr_q;
    pld_d            = pld_q;
    dest_d           = dest_q;
    link_d           = link_q;
    err_drop_d       = 1'b0;
    out_valid_d      = out_valid;
    out_is_payload_d = out_is_payload;
    out_last_d       = out_last;
    out_payload_d    = out_payload;
    unique case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (|grant) begin
          hdr_d        = hdr_arr[grant_idx];
          pld_d        = pld_arr[grant_idx];
          dest_d       = sel_dest;
          link_d       = grant_idx;
          last_grant_d = grant_idx;
          if (dest_ok) begin
            state_d          = HDR;
            out_valid_d      = 1'b1;
            out_is_payload_d = 1'b0;
            out_last_d       = !hdr_arr[grant_idx][FMT_DATA_BIT];
            out_payload_d    = '0;
          end else begin
            err_drop_d = 1'b1;
          end
        end
      end
      HDR: begin
        if (accept) begin
          if (has_data) begin
            state_d          = PLD;
            out_is_payload_d = 1'b1;
            out_last_d       = 1'b1;
            out_payload_d    = pld_q;
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
      end
      PLD: begin
        if (accept) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_grant_q   <= IDX_W'(NUM_LINKS - 1);
      hdr_q          <= '0;
      pld_q          <= '0;
      dest_q         <= '0;
      link_q         <= '0;
      err_drop       <= 1'b0;
      out_valid      <= 1'b0;
      out_is_payload <= 1'b0;
      out_last       <= 1'b0;
      out_payload    <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      hdr_q          <= hdr_d;
      pld_q          <= pld_d;
      dest_q         <= dest_d;
      link_q         <= link_d;
      err_drop       <= err_drop_d;
      out_valid      <= out_valid_d;
      out_is_payload <= out_is_payload_d;
      out_last       <= out_last_d;
      out_payload    <= out_payload_d;
    end
  end

`ifdef CEA_GRANT_STATS_EN
  // Saturating per-link grant counters, dropped requests included
  for (genvar i = 0; i < NUM_LINKS; i++) begin : g_stats
    logic [15:0] cnt_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (grant[i] && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign grant_count[i*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_completion_egress_arbiter.sv
// Randomised and directed bench for completion_egress_arbiter against a
// beat-queue reference model.
module tb_completion_egress_arbiter;

  localparam int unsigned NL = 4;
  localparam int unsigned HW = 96;
  localparam int unsigned PW = 32;
  localparam int unsigned DW = 3;
  localparam int unsigned NS = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NL-1:0]     req_valid;
  logic [NL*HW-1:0]  req_header;
  logic [NL*PW-1:0]  req_payload;
  logic [NL*DW-1:0]  req_dest;
  logic [NL-1:0]     req_ready;
  logic              out_valid;
  logic [HW-1:0]     out_header;
  logic [PW-1:0]     out_payload;
  logic [DW-1:0]     out_dest;
  logic              out_is_payload;
  logic              out_last;
  logic [1:0]        out_link_id;
  logic [NS-1:0]     sub_ready;
  logic              err_drop;
`ifdef CEA_GRANT_STATS_EN
  logic [NL*16-1:0]  grant_count;
`endif

  always #5 clk = ~clk;

  completion_egress_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_header     (req_header),
    .req_payload    (req_payload),
    .req_dest       (req_dest),
    .req_ready      (req_ready),
    .out_valid      (out_valid),
    .out_header     (out_header),
    .out_payload    (out_payload),
    .out_dest       (out_dest),
    .out_is_payload (out_is_payload),
    .out_last       (out_last),
    .out_link_id    (out_link_id),
    .sub_ready      (sub_ready),
    .err_drop       (err_drop)
`ifdef CEA_GRANT_STATS_EN
    ,
    .grant_count    (grant_count)
`endif
  );

  typedef struct {
    logic [HW-1:0] hdr;
    logic [PW-1:0] pld;
    logic [DW-1:0] dest;
    logic          is_pld;
    logic          last;
    int            link;
  } beat_t;

  // Reference model: pending beats of the packet in flight, RR pointer, drop flag
  beat_t       mq[$];
  int          m_last;
  logic        m_err;
  int unsigned m_cnt [NL];

  // Requester images driven onto the DUT
  logic          r_v    [NL];
  logic [HW-1:0] r_hdr  [NL];
  logic [PW-1:0] r_pld  [NL];
  logic [DW-1:0] r_dest [NL];

  int n_vec = 0;
  int n_err = 0;
  bit rand_mode = 1'b0;
  bit refill    = 1'b0;

  task automatic check(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NL; i++) begin
      req_valid[i]               = r_v[i];
      req_header[i*HW +: HW]     = r_hdr[i];
      req_payload[i*PW +: PW]    = r_pld[i];
      req_dest[i*DW +: DW]       = r_dest[i];
    end
  endtask

  task automatic set_req(input int i, input logic [HW-1:0] h, input logic [PW-1:0] p, input logic [DW-1:0] d);
    r_v[i] = 1'b1; r_hdr[i] = h; r_pld[i] = p; r_dest[i] = d;
  endtask

  task automatic new_rand_req(input int i);
    logic [HW-1:0] h;
    logic [DW-1:0] d;
    h = {$urandom, $urandom, $urandom};
    d = ($urandom_range(0, 9) == 0) ? DW'($urandom_range(0, 7)) : DW'($urandom_range(1, 3));
    set_req(i, h, $urandom, d);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NL; i++) r_v[i] = 1'b0;
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= NL; k++) begin
      int j;
      j = (m_last + k) % NL;
      if (r_v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [HW-1:0] dataless(input logic [HW-1:0] h);
    logic [HW-1:0] r;
    r = h;
    r[30] = 1'b0;
    return r;
  endfunction

  // One clock: check outputs against the model, advance it, then drive new inputs
  task automatic cycle();
    int            g;
    logic [NL-1:0] exp_rdy;
    beat_t         b;
    #1;
    g = (mq.size() == 0 && rst_n) ? rr_pick() : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", HW'(req_ready), HW'(exp_rdy));
    check("err_drop", HW'(err_drop), HW'(m_err));
    check("out_valid", HW'(out_valid), HW'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("out_header", out_header, mq[0].hdr);
      check("out_payload", HW'(out_payload), HW'(mq[0].pld));
      check("out_dest", HW'(out_dest), HW'(mq[0].dest));
      check("out_is_payload", HW'(out_is_payload), HW'(mq[0].is_pld));
      check("out_last", HW'(out_last), HW'(mq[0].last));
      check("out_link_id", HW'(out_link_id), HW'(mq[0].link));
    end

    if (!rst_n) begin
      mq.delete();
      m_last = NL - 1;
      m_err  = 1'b0;
      for (int i = 0; i < NL; i++) m_cnt[i] = 0;
    end else if (mq.size() != 0) begin
      m_err = 1'b0;
      if (sub_ready[2'(mq[0].dest)]) void'(mq.pop_front());
    end else begin
      m_err = 1'b0;
      if (g >= 0) begin
        m_last = g;
        if (m_cnt[g] < 16'hFFFF) m_cnt[g]++;
        if (r_dest[g] >= 1 && r_dest[g] <= NS - 1) begin
          b.hdr = r_hdr[g]; b.pld = '0; b.dest = r_dest[g];
          b.is_pld = 1'b0; b.last = !r_hdr[g][30]; b.link = g;
          mq.push_back(b);
          if (r_hdr[g][30]) begin
            b.pld = r_pld[g]; b.is_pld = 1'b1; b.last = 1'b1;
            mq.push_back(b);
          end
        end else begin
          m_err = 1'b1;
        end
      end
    end

    @(negedge clk);
    if (g >= 0 && !refill) r_v[g] = 1'b0;
    if (rand_mode) begin
      for (int i = 0; i < NL; i++) begin
        if (!r_v[i] && $urandom_range(0, 3) == 0) new_rand_req(i);
        else if (r_v[i] && $urandom_range(0, 31) == 0) r_v[i] = 1'b0;
      end
      sub_ready = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '1;
      rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
    end
    pack();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [HW-1:0] h;
    for (int i = 0; i < NL; i++) begin
      r_v[i] = 1'b0; r_hdr[i] = '0; r_pld[i] = '0; r_dest[i] = '0; m_cnt[i] = 0;
    end
    m_last = NL - 1;
    m_err  = 1'b0;
    rst_n  = 1'b0;
    sub_ready = '1;
    pack();
    @(negedge clk);
    @(negedge clk);

    // Reset held with every link requesting; then fairness with continuous requests
    for (int i = 0; i < NL; i++) begin
      h = {$urandom, $urandom, $urandom};
      set_req(i, dataless(h), $urandom, 3'd1);
    end
    pack();
    run(2);
    check("rst_out_header", out_header, '0);
    check("rst_out_payload", HW'(out_payload), '0);
    check("rst_out_link_id", HW'(out_link_id), '0);
    check("rst_out_last", HW'(out_last), '0);
    rst_n  = 1'b1;
    refill = 1'b1;
    pack();
    run(10);
    refill = 1'b0;
    clear_reqs();
    pack();
    run(3);

    // Memory read completion with data on link 1
    h = {$urandom, $urandom, $urandom};
    h[30] = 1'b1;
    set_req(1, h, 32'hDEADBEEF, 3'd2);
    sub_ready = 4'b0100;
    pack();
    run(5);

    // I/O header held under backpressure, competing request must wait
    sub_ready = 4'b0111;
    h = {$urandom, $urandom, $urandom};
    set_req(0, dataless(h), $urandom, 3'd3);
    pack();
    cycle();
    set_req(2, dataless(h), $urandom, 3'd1);
    pack();
    run(5);
    sub_ready = 4'b1111;
    pack();
    run(4);

    // Invalid destination on link 2 dropped, link 3 next
    clear_reqs();
    h = {$urandom, $urandom, $urandom};
    set_req(1, dataless(h), $urandom, 3'd1);
    pack();
    run(3);
    set_req(2, h, $urandom, 3'd0);
    set_req(3, dataless(h), $urandom, 3'd1);
    pack();
    run(5);

    // Reset while the payload beat is pending
    h = {$urandom, $urandom, $urandom};
    h[30] = 1'b1;
    set_req(0, h, $urandom, 3'd2);
    pack();
    run(2);
    rst_n = 1'b0;
    pack();
    cycle();
    rst_n = 1'b1;
    pack();
    run(4);

    // Random traffic with backpressure, bad codes and occasional resets
    rand_mode = 1'b1;
    run(4000);
    rand_mode = 1'b0;
    rst_n = 1'b1;
    clear_reqs();
    sub_ready = '1;
    pack();
    run(6);

`ifdef CEA_GRANT_STATS_EN
    for (int i = 0; i < NL; i++)
      check("grant_count", HW'(grant_count[i*16 +: 16]), HW'(m_cnt[i]));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
